// File: rtl/cache_line_writeback_if.sv
// -----------------------------------------------------------------------------
// cache_line_writeback_if
//   Bundles the request, cache-data-unit read and backing-memory beat
//   signals of the line writeback engine.
//   master : the writeback engine (cache_line_writeback)
//   slave  : the surrounding logic / memory that it talks to
//   Request      : start_i, line_idx_i, mem_base_i -> busy_o, done_o
//   Data unit    : cdu_addr_o, cdu_width_o -> cdu_rdata_i (1-cycle sync read)
//   Memory beats : mem_valid_o, mem_addr_o, mem_data_o, mem_last_o <- mem_ready_i
// -----------------------------------------------------------------------------
interface cache_line_writeback_if #(
    parameter int ADDR_WIDTH     = 8,
    parameter int LINE_WIDTH     = 128,
    parameter int BEAT_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32
);
    localparam int OFF = $clog2(LINE_WIDTH / 8);

    logic                      start_i;
    logic [ADDR_WIDTH-OFF-1:0] line_idx_i;
    logic [MEM_ADDR_WIDTH-1:0] mem_base_i;
    logic                      busy_o;
    logic                      done_o;

    logic [ADDR_WIDTH-1:0]     cdu_addr_o;
    logic [1:0]                cdu_width_o;
    logic [LINE_WIDTH-1:0]     cdu_rdata_i;

    logic                      mem_valid_o;
    logic                      mem_ready_i;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic [BEAT_WIDTH-1:0]     mem_data_o;
    logic                      mem_last_o;

    modport master (
        input  start_i, line_idx_i, mem_base_i, cdu_rdata_i, mem_ready_i,
        output busy_o, done_o, cdu_addr_o, cdu_width_o,
               mem_valid_o, mem_addr_o, mem_data_o, mem_last_o
    );

    modport slave (
        output start_i, line_idx_i, mem_base_i, cdu_rdata_i, mem_ready_i,
        input  busy_o, done_o, cdu_addr_o, cdu_width_o,
               mem_valid_o, mem_addr_o, mem_data_o, mem_last_o
    );
endinterface

// File: rtl/cache_line_writeback.sv
// -----------------------------------------------------------------------------
// cache_line_writeback
//   Dirty-line eviction engine. On start it reads one full line from the cache
//   data unit (line-width access), holds it in a local line buffer and streams
//   it to backing memory as LINE_WIDTH/BEAT_WIDTH beats over valid/ready.
//   Ports:
//     clk_i  : clock, all state on the rising edge
//     rst_i  : asynchronous active-high reset, aborts any transfer
//     bus    : cache_line_writeback_if.master (request, data unit, memory beats)
//   Sequence: IDLE -> RD -> CAP -> SEND (one state per beat handshake) -> DONE.
// -----------------------------------------------------------------------------
module cache_line_writeback #(
    parameter int ADDR_WIDTH     = 8,
    parameter int LINE_WIDTH     = 128,
    parameter int BEAT_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    cache_line_writeback_if.master bus
);
    localparam int OFF        = $clog2(LINE_WIDTH / 8);
    localparam int NBEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int BCW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_SHIFT = $clog2(BEAT_WIDTH / 8);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [BCW-1:0]            beat;
    logic [LINE_WIDTH-1:0]     line_buf;
    logic [MEM_ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0]     cdu_addr;
    logic [BEAT_WIDTH-1:0]     beat_data;
    logic                      is_last;
    logic                      accept;
    logic                      beat_fire;

    assign is_last   = (beat == LAST_BEAT);
    assign accept    = (state == S_IDLE) && bus.start_i;
    // ready only counts while a beat is actually presented
    assign beat_fire = (state == S_SEND) && bus.mem_ready_i;

    // ---- control: state register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start_i) state_nxt = S_RD;
            // data unit samples cdu_addr at the end of RD, data is valid in CAP
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = S_SEND;
            S_SEND: if (beat_fire && is_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- datapath: request latch, line capture, beat counter ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cdu_addr <= '0;
            base     <= '0;
            line_buf <= '0;
            beat     <= '0;
        end else begin
            if (accept) begin
                cdu_addr <= {bus.line_idx_i, {OFF{1'b0}}};
                // force line alignment so beat offsets never carry past OFF
                base     <= {bus.mem_base_i[MEM_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            end
            if (state == S_CAP) begin
                line_buf <= bus.cdu_rdata_i;
                beat     <= '0;
            end else if (beat_fire && !is_last) begin
                beat     <= beat + 1'b1;
            end
        end
    end

    // ---- beat output: little-endian slice of the captured line ----
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (beat == BCW'(i)) begin
                beat_data = line_buf[i*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = (state == S_DONE);
    assign bus.cdu_addr_o  = cdu_addr;
    assign bus.cdu_width_o = 2'b00;
    assign bus.mem_valid_o = (state == S_SEND);
    assign bus.mem_last_o  = (state == S_SEND) && is_last;
    assign bus.mem_data_o  = beat_data;
    // modulo 2^MEM_ADDR_WIDTH by construction of the adder width
    assign bus.mem_addr_o  = base + (MEM_ADDR_WIDTH'(beat) << BEAT_SHIFT);

    // a presented beat must hold until it is taken
    property p_beat_hold;
        @(posedge clk_i) disable iff (rst_i)
        (bus.mem_valid_o && !bus.mem_ready_i) |=>
            (bus.mem_valid_o && $stable(bus.mem_addr_o) &&
             $stable(bus.mem_data_o) && $stable(bus.mem_last_o));
    endproperty
    a_beat_hold: assert property (p_beat_hold);

    property p_done_single;
        @(posedge clk_i) disable iff (rst_i)
        bus.done_o |=> !bus.done_o;
    endproperty
    a_done_single: assert property (p_done_single);

endmodule

// File: tb/tb_cache_line_writeback.sv
module tb_cache_line_writeback;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [127:0] mem_lines [16];
    logic [31:0]  q_data [$];
    logic [31:0]  q_addr [$];
    logic         q_last [$];
    logic [31:0]  st_addr [$];
    logic [31:0]  st_data [$];
    logic         st_valid [$];
    int           done_cnt;
    int           width_bad;

    cache_line_writeback_if #(
        .ADDR_WIDTH(8), .LINE_WIDTH(128), .BEAT_WIDTH(32), .MEM_ADDR_WIDTH(32)
    ) bus ();

    cache_line_writeback #(
        .ADDR_WIDTH(8), .LINE_WIDTH(128), .BEAT_WIDTH(32), .MEM_ADDR_WIDTH(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cache data unit model: 1-cycle synchronous line read
    always @(posedge clk) begin
        bus.cdu_rdata_i <= mem_lines[bus.cdu_addr_o[7:4]];
    end

    // beat / done monitor
    always @(posedge clk) begin
        if (!rst && bus.mem_valid_o && bus.mem_ready_i) begin
            q_data.push_back(bus.mem_data_o);
            q_addr.push_back(bus.mem_addr_o);
            q_last.push_back(bus.mem_last_o);
        end
        if (!rst && bus.done_o) done_cnt++;
        if (bus.cdu_width_o !== 2'b00) width_bad++;
    end

    // drives one request from a negedge; returns at the negedge of the DONE cycle
    // (or after the cycle budget with dcyc = -1). Cycle 1 is the cycle after edge 0.
    task automatic run_xfer(input logic [3:0] idx, input logic [31:0] base,
                            input int stall_beat, input int stall_len,
                            input int extra_start_cyc, input bit corrupt,
                            output int vcyc, output int dcyc);
        int cyc;
        int n0;
        int stall_left;
        logic [127:0] saved;
        saved = mem_lines[idx];
        n0 = q_data.size();
        stall_left = stall_len;
        vcyc = -1;
        dcyc = -1;
        bus.line_idx_i  = idx;
        bus.mem_base_i  = base;
        bus.mem_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 60) begin
            if (bus.mem_valid_o && vcyc < 0) vcyc = cyc;
            if (bus.done_o) begin
                dcyc = cyc;
                break;
            end
            if (corrupt && cyc == 3) mem_lines[idx] = ~saved;
            if (cyc == extra_start_cyc) begin
                bus.start_i    = 1'b1;
                bus.line_idx_i = 4'd9;
                bus.mem_base_i = 32'h0000_2000;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.mem_valid_o && (q_data.size() - n0) == stall_beat && stall_left > 0) begin
                bus.mem_ready_i = 1'b0;
                stall_left--;
                st_addr.push_back(bus.mem_addr_o);
                st_data.push_back(bus.mem_data_o);
                st_valid.push_back(bus.mem_valid_o);
            end else begin
                bus.mem_ready_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 1'b0;
        mem_lines[idx] = saved;
    endtask

    task automatic test_reset;
        tests++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.mem_valid_o !== 1'b0 ||
            bus.mem_last_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b expected all 0",
                     bus.busy_o, bus.done_o, bus.mem_valid_o, bus.mem_last_o);
        end
        tests++;
        if (bus.cdu_addr_o !== 8'h00 || bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: cdu_addr=%h mem_addr=%h mem_data=%h expected 0",
                     bus.cdu_addr_o, bus.mem_addr_o, bus.mem_data_o);
        end
        tests++;
        if (bus.cdu_width_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_width: got %b expected 00", bus.cdu_width_o);
        end
    endtask

    task automatic test_basic;
        int vc, dc, n0, d0;
        logic [127:0] line;
        line = mem_lines[5];
        n0 = q_data.size();
        d0 = done_cnt;
        run_xfer(4'd5, 32'h0000_1000, -1, 0, -1, 1'b1, vc, dc);
        tests++;
        if (vc !== 3) begin
            fails++;
            $display("FAIL basic_valid_cycle: got %0d expected 3", vc);
        end
        tests++;
        if (dc !== 7) begin
            fails++;
            $display("FAIL basic_done_cycle: got %0d expected 7", dc);
        end
        tests++;
        if (bus.busy_o !== 1'b1 || bus.mem_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_state: busy=%b valid=%b expected busy=1 valid=0",
                     bus.busy_o, bus.mem_valid_o);
        end
        tests++;
        if (bus.cdu_addr_o !== 8'h50) begin
            fails++;
            $display("FAIL basic_cdu_addr: got %h expected 50", bus.cdu_addr_o);
        end
        tests++;
        if (q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL basic_beat_count: got %0d expected 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[n0+i] !== line[i*32 +: 32] || q_addr[n0+i] !== 32'h1000 + 32'(4*i) ||
                    q_last[n0+i] !== (i == 3)) begin
                    fails++;
                    $display("FAIL basic_beat[%0d]: got %h@%h last=%b expected %h@%h last=%b",
                             i, q_data[n0+i], q_addr[n0+i], q_last[n0+i],
                             line[i*32 +: 32], 32'h1000 + 32'(4*i), (i == 3));
                end
            end
        end
        @(negedge clk);
        tests++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || done_cnt !== d0 + 1) begin
            fails++;
            $display("FAIL basic_after_done: busy=%b done=%b pulses=%0d expected 0 0 %0d",
                     bus.busy_o, bus.done_o, done_cnt - d0, 1);
        end
    endtask

    task automatic test_stall;
        int vc, dc, n0;
        logic [127:0] line;
        line = mem_lines[5];
        n0 = q_data.size();
        st_addr.delete();
        st_data.delete();
        st_valid.delete();
        run_xfer(4'd5, 32'h0000_1000, 2, 3, -1, 1'b0, vc, dc);
        tests++;
        if (dc !== 10) begin
            fails++;
            $display("FAIL stall_done_cycle: got %0d expected 10", dc);
        end
        tests++;
        if (st_addr.size() !== 3) begin
            fails++;
            $display("FAIL stall_cycles: got %0d expected 3", st_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (st_valid[i] !== 1'b1 || st_addr[i] !== 32'h1008 || st_data[i] !== 32'h2222_2222) begin
                    fails++;
                    $display("FAIL stall_hold[%0d]: valid=%b %h@%h expected 1 22222222@00001008",
                             i, st_valid[i], st_data[i], st_addr[i]);
                end
            end
        end
        tests++;
        if (q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL stall_beat_count: got %0d expected 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[n0+i] !== line[i*32 +: 32] || q_addr[n0+i] !== 32'h1000 + 32'(4*i)) begin
                    fails++;
                    $display("FAIL stall_beat[%0d]: got %h@%h expected %h@%h",
                             i, q_data[n0+i], q_addr[n0+i], line[i*32 +: 32], 32'h1000 + 32'(4*i));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        int vc, dc, n0;
        n0 = q_data.size();
        run_xfer(4'd5, 32'h0000_100B, -1, 0, -1, 1'b0, vc, dc);
        tests++;
        if (bus.cdu_addr_o !== 8'h50) begin
            fails++;
            $display("FAIL misaligned_cdu_addr: got %h expected 50", bus.cdu_addr_o);
        end
        tests++;
        if (q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL misaligned_beat_count: got %0d expected 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_addr[n0+i] !== 32'h1000 + 32'(4*i)) begin
                    fails++;
                    $display("FAIL misaligned_addr[%0d]: got %h expected %h",
                             i, q_addr[n0+i], 32'h1000 + 32'(4*i));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int vc, dc, n0, d0;
        logic [127:0] l5;
        logic [127:0] l7;
        l5 = mem_lines[5];
        l7 = mem_lines[7];
        n0 = q_data.size();
        d0 = done_cnt;
        // a start pulse while in SEND must be ignored
        run_xfer(4'd5, 32'h0000_1000, -1, 0, 4, 1'b0, vc, dc);
        tests++;
        if (dc !== 7 || q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL busy_start_ignored: done_cycle=%0d beats=%0d expected 7 4",
                     dc, q_data.size() - n0);
        end else begin
            tests++;
            if (q_data[n0+3] !== l5[127:96] || q_addr[n0+3] !== 32'h100C) begin
                fails++;
                $display("FAIL busy_last_beat: got %h@%h expected %h@0000100c",
                         q_data[n0+3], q_addr[n0+3], l5[127:96]);
            end
        end
        @(negedge clk);
        tests++;
        if (bus.busy_o !== 1'b0 || done_cnt !== d0 + 1) begin
            fails++;
            $display("FAIL busy_one_done: busy=%b pulses=%0d expected 0 1", bus.busy_o, done_cnt - d0);
        end
        // start in the cycle after DONE is accepted
        n0 = q_data.size();
        run_xfer(4'd7, 32'h0000_3000, -1, 0, -1, 1'b0, vc, dc);
        tests++;
        if (vc !== 3 || dc !== 7) begin
            fails++;
            $display("FAIL b2b_timing: valid_cycle=%0d done_cycle=%0d expected 3 7", vc, dc);
        end
        tests++;
        if (q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL b2b_beat_count: got %0d expected 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[n0+i] !== l7[i*32 +: 32] || q_addr[n0+i] !== 32'h3000 + 32'(4*i)) begin
                    fails++;
                    $display("FAIL b2b_beat[%0d]: got %h@%h expected %h@%h",
                             i, q_data[n0+i], q_addr[n0+i], l7[i*32 +: 32], 32'h3000 + 32'(4*i));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int vc, dc, n0;
        logic [127:0] l3;
        l3 = mem_lines[3];
        n0 = q_data.size();
        run_xfer(4'd3, 32'hFFFF_FFF0, -1, 0, -1, 1'b0, vc, dc);
        tests++;
        if (q_data.size() - n0 !== 4) begin
            fails++;
            $display("FAIL wrap_beat_count: got %0d expected 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_addr[n0+i] !== 32'hFFFF_FFF0 + 32'(4*i) || q_data[n0+i] !== l3[i*32 +: 32]) begin
                    fails++;
                    $display("FAIL wrap_beat[%0d]: got %h@%h expected %h@%h",
                             i, q_data[n0+i], q_addr[n0+i], l3[i*32 +: 32], 32'hFFFF_FFF0 + 32'(4*i));
                end
            end
        end
        tests++;
        if (width_bad !== 0) begin
            fails++;
            $display("FAIL wrap_width: %0d cycles with nonzero cdu_width expected 0", width_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_send;
        int n0, d0, cyc;
        n0 = q_data.size();
        d0 = done_cnt;
        bus.line_idx_i  = 4'd5;
        bus.mem_base_i  = 32'h0000_1000;
        bus.mem_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        cyc = 1;
        while ((q_data.size() - n0) < 1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc !== 4 || bus.mem_addr_o !== 32'h1004) begin
            fails++;
            $display("FAIL midrst_setup: cycle=%0d addr=%h expected 4 00001004", cyc, bus.mem_addr_o);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.mem_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: valid=%b busy=%b expected 0 0", bus.mem_valid_o, bus.busy_o);
        end
        @(negedge clk);
        tests++;
        if (bus.mem_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
            bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 32'h0 || bus.cdu_addr_o !== 8'h0) begin
            fails++;
            $display("FAIL midrst_values: valid=%b busy=%b done=%b addr=%h data=%h cdu=%h expected all 0",
                     bus.mem_valid_o, bus.busy_o, bus.done_o, bus.mem_addr_o,
                     bus.mem_data_o, bus.cdu_addr_o);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (q_data.size() - n0 !== 1 || done_cnt !== d0) begin
            fails++;
            $display("FAIL midrst_abort: beats=%0d pulses=%0d expected 1 0",
                     q_data.size() - n0, done_cnt - d0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done_cnt = 0;
        width_bad = 0;
        for (int i = 0; i < 16; i++) mem_lines[i] = {4{8'(i), 8'hA5, 8'h5A, 8'(i)}};
        mem_lines[3] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        mem_lines[5] = 128'h33333333_22222222_11111111_00000000;
        mem_lines[7] = 128'h77777777_66666666_55555555_44444444;
        mem_lines[9] = 128'h99999999_88888888_0BADF00D_DEADBEEF;
        rst = 1'b1;
        bus.start_i     = 1'b0;
        bus.line_idx_i  = '0;
        bus.mem_base_i  = '0;
        bus.mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_stall();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
